morse_seq_buffer: RTL and testbench

Parametrised Morse sequence buffer between the sequence separator and the translator/display stage. Each write strobe appends up to two encoded symbol sequences in arrival order, with invalid lanes skipped. The buffer exposes a valid/ready drain port (oldest first), a flattened snapshot captured on `enter`, and occupancy and overflow status. It replaces the fixed 16×10-bit storage with configurable width and depth, and defines behaviour when full.

---
 rtl/morse_seq_buffer.sv | 150 +++++++++++++++
 tb/tb_morse_seq_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_seq_buffer.sv
// morse_seq_buffer
// Circular buffer for encoded Morse symbol sequences. It sits between the
// sequence separator and the translator/display stage.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_stb            appends first_seq then sec_seq; lanes whose top two bits
//                     are 2'b11 ("no sequence") are skipped
//   rd_valid/rd_ready drain port, oldest first; rd_data is all ones when empty
//   enter             captures store_seqs (newest in the low field); snap_valid
//                     pulses for the cycle after the capture
//   count/full/empty  occupancy status
//   overflow          sticky until reset: a valid sequence was lost
// Build option: define MORSE_SEQBUF_WRAP_EN to overwrite the oldest entries
// when full. Without it, lanes that do not fit are dropped.
module morse_seq_buffer #(
  parameter int SEQ_W = 10,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_stb,
  input  logic [SEQ_W-1:0]       first_seq,
  input  logic [SEQ_W-1:0]       sec_seq,
  input  logic                   enter,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [SEQ_W-1:0]       rd_data,
  output logic [DEPTH*SEQ_W-1:0] store_seqs,
  output logic                   snap_valid,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [SEQ_W-1:0] ONES = '1;

  logic [SEQ_W-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic [DEPTH*SEQ_W-1:0] r_snap;
  logic                   r_snap_valid;
  logic                   r_overflow;

  logic                   w_v0;
  logic                   w_v1;
  logic                   w_pop;
  logic                   w_acc0;
  logic                   w_acc1;
  logic                   w_drop;
  logic [SEQ_W-1:0]       w_d0;
  logic [PTR_W-1:0]       w_wptr_p1;
  logic [PTR_W-1:0]       w_wptr_nxt;
  logic [PTR_W-1:0]       w_rptr_nxt;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [DEPTH*SEQ_W-1:0] w_snap;

  // Modulo-DEPTH pointer advance. The increment never exceeds 2, so one
  // conditional subtraction is enough, and DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input int unsigned inc);
    int unsigned t;
    t = 32'(p) + inc;
    if (t >= DEPTH_U) t = t - DEPTH_U;
    return PTR_W'(t);
  endfunction

  always_comb begin
    int unsigned cnt;
    int unsigned free;
    int unsigned want;
    int unsigned ovr;
    w_v0  = wr_stb && (first_seq[SEQ_W-1 -: 2] != 2'b11);
    w_v1  = wr_stb && (sec_seq[SEQ_W-1 -: 2] != 2'b11);
    w_pop = (r_count != '0) && rd_ready;
    cnt   = 32'(r_count);
    // A pop in this cycle frees its slot for this cycle's writes.
    free  = DEPTH_U - cnt + (w_pop ? 32'd1 : 32'd0);
`ifdef MORSE_SEQBUF_WRAP_EN
    w_acc0 = w_v0;
    w_acc1 = w_v1;
`else
    w_acc0 = w_v0 && (free >= 32'd1);
    // Lane 1 never overtakes a dropped lane 0.
    w_acc1 = w_v1 && !(w_v0 && !w_acc0) && (free >= (w_acc0 ? 32'd2 : 32'd1));
`endif
    want = (w_acc0 ? 32'd1 : 32'd0) + (w_acc1 ? 32'd1 : 32'd0);
    // Writes beyond the free space overwrite the oldest entries. This is only
    // possible when wrapping is enabled.
    ovr  = (want > free) ? (want - free) : 32'd0;
    w_drop = (w_v0 && !w_acc0) || (w_v1 && !w_acc1) || (ovr != 32'd0);
    // When lane 0 is skipped, lane 1 takes the first free slot.
    w_d0 = w_acc0 ? first_seq : sec_seq;
    w_wptr_p1   = ptr_add(r_wptr, 32'd1);
    w_wptr_nxt  = ptr_add(r_wptr, want);
    w_rptr_nxt  = ptr_add(r_rptr, (w_pop ? 32'd1 : 32'd0) + ovr);
    w_count_nxt = CNT_W'(cnt + want - (w_pop ? 32'd1 : 32'd0) - ovr);
  end

  // Snapshot view: field k holds the k-th newest entry, counted back from the
  // slot just behind the write pointer.
  always_comb begin
    int unsigned cnt;
    int unsigned idx;
    w_snap = '1;
    cnt    = 32'(r_count);
    for (int unsigned k = 0; k < DEPTH_U; k++) begin
      idx = 32'(r_wptr) + DEPTH_U - 32'd1 - k;
      if (idx >= DEPTH_U) idx = idx - DEPTH_U;
      if (k < cnt) w_snap[k*SEQ_W +: SEQ_W] = r_mem[PTR_W'(idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) r_mem[i] <= ONES;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_snap       <= '1;
      r_snap_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // When the buffer is full, the write to the popped slot comes later in
      // this block and therefore takes effect.
      if (w_pop) r_mem[r_rptr] <= ONES;
      if (w_acc0 || w_acc1) r_mem[r_wptr] <= w_d0;
      if (w_acc0 && w_acc1) r_mem[w_wptr_p1] <= sec_seq;
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_snap_valid <= enter;
      if (enter) r_snap <= w_snap;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign rd_valid   = (r_count != '0);
  assign rd_data    = r_mem[r_rptr];
  assign store_seqs = r_snap;
  assign snap_valid = r_snap_valid;
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_morse_seq_buffer.sv
// Testbench for morse_seq_buffer (SEQ_W=10, DEPTH=16). An SV queue acts as a
// reference model and drain scoreboard: accepted sequences are pushed when a
// strobe is driven, and each one is popped and compared when the DUT pops.
// Define MORSE_SEQBUF_WRAP_EN for both the bench and the RTL to check the
// wrapping build.
module tb_morse_seq_buffer;

  logic         clk;
  logic         reset;
  logic         wr_stb;
  logic [9:0]   first_seq;
  logic [9:0]   sec_seq;
  logic         enter;
  logic         rd_ready;
  logic         rd_valid;
  logic [9:0]   rd_data;
  logic [159:0] store_seqs;
  logic         snap_valid;
  logic [4:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;

  morse_seq_buffer #(.SEQ_W(10), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .first_seq(first_seq),
    .sec_seq(sec_seq), .enter(enter), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .store_seqs(store_seqs),
    .snap_valid(snap_valid), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]   mq [$];
  logic         m_ovf;
  logic [159:0] m_snap;
  logic         m_sv;
  int           n_checks;
  int           n_err;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic is_valid(input logic [9:0] v);
    return v[9:8] != 2'b11;
  endfunction

  task automatic check_all();
    logic [9:0] head;
    head = (mq.size() != 0) ? mq[0] : 10'h3FF;
    chk("count", 160'(count), 160'(mq.size()));
    chk("rd_valid", 160'(rd_valid), 160'(mq.size() != 0));
    chk("rd_data", 160'(rd_data), 160'(head));
    chk("full", 160'(full), 160'(mq.size() == 16));
    chk("empty", 160'(empty), 160'(mq.size() == 0));
    chk("overflow", 160'(overflow), 160'(m_ovf));
    chk("snap_valid", 160'(snap_valid), 160'(m_sv));
    chk("store_seqs", store_seqs, m_snap);
  endtask

  // Drives one clock cycle, advances the model from the pre-edge state, then
  // checks all outputs 1 ns after the edge.
  task automatic cycle(input logic rst, input logic ws, input logic [9:0] f,
                       input logic [9:0] s, input logic en, input logic rr);
    logic [9:0] lanes [2];
    logic       blocked;
    reset = rst; wr_stb = ws; first_seq = f; sec_seq = s; enter = en; rd_ready = rr;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_snap = '1;
      m_sv   = 1'b0;
    end else begin
      m_sv = en;
      if (en) begin
        m_snap = '1;
        for (int k = 0; k < mq.size(); k++) m_snap[k*10 +: 10] = mq[mq.size()-1-k];
      end
      if (rr && mq.size() != 0) begin
        chk("drain_order", 160'(rd_data), 160'(mq[0]));
        void'(mq.pop_front());
      end
      lanes[0] = f;
      lanes[1] = s;
      blocked  = 1'b0;
      for (int l = 0; l < 2; l++) begin
        if (ws && is_valid(lanes[l])) begin
`ifdef MORSE_SEQBUF_WRAP_EN
          if (mq.size() == 16) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
          end
          mq.push_back(lanes[l]);
`else
          if (!blocked && mq.size() < 16) mq.push_back(lanes[l]);
          else begin
            blocked = 1'b1;
            m_ovf   = 1'b1;
          end
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic fill16();
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 10'(2*i-1), 10'(2*i), 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        ws;
    logic [9:0]  f;
    logic [9:0]  s;
    logic        en;
    logic        rr;
    int unsigned cnt;
    logic [9:0]  rd;
    logic        ovf;
  } vec_t;

  vec_t         tbl [8];
  logic [159:0] exp_snap;

  initial begin
    tbl[0] = '{1'b1, 10'h005, 10'h3FF, 1'b0, 1'b0, 1, 10'h005, 1'b0};
    tbl[1] = '{1'b1, 10'h3FF, 10'h00A, 1'b0, 1'b0, 2, 10'h005, 1'b0};
    tbl[2] = '{1'b1, 10'h300, 10'h2FF, 1'b0, 1'b0, 3, 10'h005, 1'b0};
    tbl[3] = '{1'b0, 10'h012, 10'h013, 1'b0, 1'b0, 3, 10'h005, 1'b0};
    tbl[4] = '{1'b1, 10'h020, 10'h021, 1'b0, 1'b1, 4, 10'h00A, 1'b0};
    tbl[5] = '{1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 3, 10'h2FF, 1'b0};
    tbl[6] = '{1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 3, 10'h2FF, 1'b0};
    tbl[7] = '{1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 2, 10'h020, 1'b0};

    n_checks = 0; n_err = 0;
    reset = 1'b1; wr_stb = 1'b0; first_seq = '0; sec_seq = '0; enter = 1'b0; rd_ready = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_snap = '1; m_sv = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    chk("rst_empty", 160'(empty), 160'(1'b1));
    chk("rst_rd_data", 160'(rd_data), 160'(10'h3FF));

    // Directed table from reset
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, tbl[i].ws, tbl[i].f, tbl[i].s, tbl[i].en, tbl[i].rr);
      chk($sformatf("tbl%0d_count", i), 160'(count), 160'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rd", i), 160'(rd_data), 160'(tbl[i].rd));
      chk($sformatf("tbl%0d_ovf", i), 160'(overflow), 160'(tbl[i].ovf));
      chk($sformatf("tbl%0d_snapv", i), 160'(snap_valid), 160'(tbl[i].en));
      if (tbl[i].en) begin
        exp_snap = '1;
        exp_snap[29:0] = {10'h2FF, 10'h020, 10'h021};
        chk("tbl_snap", store_seqs, exp_snap);
      end
    end

    // Fill to 16, then snapshot
    cycle(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    fill16();
    chk("fill_full", 160'(full), 160'(1'b1));
    cycle(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
    chk("fill_snapv", 160'(snap_valid), 160'(1'b1));
    chk("fill_newest", 160'(store_seqs[9:0]), 160'(10'd16));
    chk("fill_oldest", 160'(store_seqs[159:150]), 160'(10'd1));

    // One more strobe with two valid lanes while full
    cycle(1'b0, 1'b1, 10'd17, 10'd18, 1'b0, 1'b0);
    chk("full_wr_snapv_pulse", 160'(snap_valid), 160'(1'b0));
    chk("full_wr_ovf", 160'(overflow), 160'(1'b1));
    chk("full_wr_count", 160'(count), 160'(5'd16));
    cycle(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
`ifdef MORSE_SEQBUF_WRAP_EN
    chk("wrap_rd_data", 160'(rd_data), 160'(10'd3));
    chk("wrap_newest", 160'(store_seqs[9:0]), 160'(10'd18));
    chk("wrap_next", 160'(store_seqs[19:10]), 160'(10'd17));
`else
    exp_snap = '1;
    for (int k = 0; k < 16; k++) exp_snap[k*10 +: 10] = 10'(16 - k);
    chk("drop_rd_data", 160'(rd_data), 160'(10'd1));
    chk("drop_unchanged", store_seqs, exp_snap);
`endif

    // Full with a same-cycle pop and one valid lane: both happen
    cycle(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    fill16();
    cycle(1'b0, 1'b1, 10'h011, 10'h3FF, 1'b0, 1'b1);
    chk("popwr_count", 160'(count), 160'(5'd16));
    chk("popwr_ovf", 160'(overflow), 160'(1'b0));
    chk("popwr_rd", 160'(rd_data), 160'(10'd2));

    // Drain three with rd_ready held high
    cycle(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 10'd1, 10'd2, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 10'd3, 10'h3FF, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("drain%0d", i), 160'(rd_data), 160'(i));
      cycle(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", 160'(empty), 160'(1'b1));
    chk("drain_ones", 160'(rd_data), 160'(10'h3FF));

    // Reset wins over a same-cycle strobe and enter
    fill16();
    cycle(1'b0, 1'b1, 10'd21, 10'd22, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 10'd7, 10'd8, 1'b1, 1'b1);
    chk("rst_pri_count", 160'(count), 160'(5'd0));
    chk("rst_pri_snapv", 160'(snap_valid), 160'(1'b0));
    chk("rst_pri_ovf", 160'(overflow), 160'(1'b0));
    chk("rst_pri_snap", store_seqs, {160{1'b1}});

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
            10'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
